// File: rtl/and_pipe_checker.sv
// Self-test sequencer for a pipelined 2-input AND: sweeps the four input
// combinations, compares the DUT result LATENCY cycles later and reports a verdict.
module and_pipe_checker #(
   parameter int LATENCY = 2,
   parameter int CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vectors,
   output logic             dut_a,
   output logic             dut_b,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_fail_idx
);

   localparam int DRAIN_W = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t               state;
   logic [CNT_W-1:0]     idx;
   logic [CNT_W-1:0]     idx_nxt;
   logic [CNT_W-1:0]     nv_q;
   logic [DRAIN_W-1:0]   drain_cnt;

   logic [LATENCY-1:0]   vld_p;
   logic [LATENCY-1:0]   exp_p;
   logic [CNT_W-1:0]     idx_p [LATENCY];

   logic                 mismatch;
   logic [CNT_W-1:0]     err_nxt;
   logic [CNT_W-1:0]     first_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Stage p0..p(LATENCY-1): expected value travels with the vector index
   // currently presented on dut_a/dut_b.
   always_ff @(posedge clock) begin
      if (!reset) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= (state == RUN);
         for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
      end
   end

   always_ff @(posedge clock) begin
      exp_p[0] <= dut_a & dut_b;
      idx_p[0] <= idx;
      for (int s = 1; s < LATENCY; s++) begin
         exp_p[s] <= exp_p[s-1];
         idx_p[s] <= idx_p[s-1];
      end
   end

   // Compare stage: last pipeline slot lines up with dut_out this cycle.
   always_comb begin
      idx_nxt   = idx + CNT_W'(1);
      mismatch  = vld_p[LATENCY-1] && (exp_p[LATENCY-1] != dut_out);
      err_nxt   = err_count;
      first_nxt = first_fail_idx;
      if (mismatch) begin
         err_nxt = sat_inc(err_count);
         if (err_count == '0) first_nxt = idx_p[LATENCY-1];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         idx            <= '0;
         nv_q           <= '0;
         drain_cnt      <= '0;
         err_count      <= '0;
         first_fail_idx <= '0;
         dut_a          <= 1'b0;
         dut_b          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
      end else begin
         err_count      <= err_nxt;
         first_fail_idx <= first_nxt;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  nv_q           <= num_vectors;
                  idx            <= '0;
                  err_count      <= '0;
                  first_fail_idx <= '0;
                  dut_a          <= 1'b0;
                  dut_b          <= 1'b0;
                  if (num_vectors != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (idx == nv_q - CNT_W'(1)) begin
                  state     <= DRAIN;
                  dut_a     <= 1'b0;
                  dut_b     <= 1'b0;
                  drain_cnt <= DRAIN_W'(LATENCY - 1);
               end else begin
                  idx   <= idx_nxt;
                  dut_a <= idx_nxt[0];
                  dut_b <= idx_nxt[1];
               end
            end
            DRAIN: begin
               // The final compare lands on the last drain cycle, so the verdict uses err_nxt.
               if (drain_cnt == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0);
               end else begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_and_pipe_checker.sv
// Bench for and_pipe_checker: table of directed runs, reset-abort sequence and
// random-response runs scored by a per-vector reference model.
module tb_and_pipe_checker;
   localparam int L  = 2;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] num_vectors = '0;
   logic          dut_a, dut_b, dut_out, busy, done, pass;
   logic [CW-1:0] err_count, first_fail_idx;

   int total = 0;
   int bad   = 0;

   logic gold_mode = 1'b0;
   logic drv = 1'b0;
   logic g1 = 1'b0, g2 = 1'b0;
   logic resp [256];
   int   junk_kind = 0;

   always #5 clk = ~clk;

   // Golden 2-cycle registered AND acting as the device under test.
   always @(posedge clk) begin
      g1 <= dut_a & dut_b;
      g2 <= g1;
   end
   assign dut_out = gold_mode ? g2 : drv;

   and_pipe_checker #(.LATENCY(L), .CNT_W(CW)) u_dut (
      .clock          (clk),
      .reset          (reset),
      .start          (start),
      .num_vectors    (num_vectors),
      .dut_a          (dut_a),
      .dut_b          (dut_b),
      .dut_out        (dut_out),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_fail_idx (first_fail_idx)
   );

   typedef struct {
      string name;
      int    n;
      bit    gm;
      int    fill;   // 0 all-zero, 1 all-one, 2 inverted, 3 correct
      bit    poke;
      int    e_err;
      int    e_first;
      int    e_pass;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic logic junk();
      if (junk_kind == 0) return 1'b0;
      if (junk_kind == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic and_of(input int i);
      return ((i % 4) == 3);
   endfunction

   task automatic fill_resp(input int kind, input int n);
      for (int i = 0; i < 256; i++) begin
         case (kind)
            0:       resp[i] = 1'b0;
            1:       resp[i] = 1'b1;
            2:       resp[i] = ~and_of(i);
            default: resp[i] = and_of(i);
         endcase
      end
      junk_kind = (kind == 0) ? 0 : (kind == 1) ? 1 : 2;
      if (n < 0) junk_kind = 2;
   endtask

   task automatic ref_model(input int n, output int e, output int f, output int p);
      e = 0;
      f = 0;
      for (int i = 0; i < n; i++) begin
         if (resp[i] != and_of(i)) begin
            if (e == 0) f = i;
            if (e < (1 << CW) - 1) e++;
         end
      end
      p = (e == 0) ? 1 : 0;
   endtask

   task automatic run(input string name, input int n, input bit gm, input bit poke,
                      input int e_err, input int e_first, input int e_pass);
      int busy_cnt = 0;
      int stim_bad = 0;
      int busy_exp;
      logic ea, eb;
      busy_exp  = (n > 0) ? n + L : 0;
      gold_mode = gm;
      @(negedge clk);
      num_vectors = n[CW-1:0];
      start = 1'b1;
      drv   = junk();
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < busy_exp; k++) begin
         drv = (k >= L && k - L < n) ? resp[k-L] : junk();
         if (busy === 1'b1) busy_cnt++;
         ea = (k < n) && ((k % 2) == 1);
         eb = (k < n) && (((k / 2) % 2) == 1);
         if (dut_a !== ea || dut_b !== eb) stim_bad++;
         if (poke && k == 3) begin
            start = 1'b1;
            num_vectors = 8'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      check({name, ".busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
      check({name, ".stimulus"},    32'(stim_bad), 32'd0);
      check({name, ".done"},        32'(done), 32'd1);
      check({name, ".busy_low"},    32'(busy), 32'd0);
      check({name, ".pass"},        32'(pass), 32'(e_pass));
      check({name, ".err_count"},   32'(err_count), 32'(e_err));
      check({name, ".first_fail"},  32'(first_fail_idx), 32'(e_first));
      check({name, ".ab_idle"},     32'({dut_a, dut_b}), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int e, f, p, n;

      tbl[0] = '{"gold8",     8,   1'b1, 3, 1'b0, 0,   0, 1};
      tbl[1] = '{"stuck0_8",  8,   1'b0, 0, 1'b0, 2,   3, 0};
      tbl[2] = '{"stuck1_8",  8,   1'b0, 1, 1'b0, 6,   0, 0};
      tbl[3] = '{"zero_vec",  0,   1'b0, 0, 1'b0, 0,   0, 1};
      tbl[4] = '{"stuck0_4",  4,   1'b0, 0, 1'b0, 1,   3, 0};
      tbl[5] = '{"stuck1_3",  3,   1'b0, 1, 1'b0, 3,   0, 0};
      tbl[6] = '{"inv255",    255, 1'b0, 2, 1'b1, 255, 0, 0};
      tbl[7] = '{"script1",   1,   1'b0, 3, 1'b0, 0,   0, 1};

      // Reset state
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.outputs", 32'({dut_a, dut_b, busy, done, pass}), 32'd0);
      check("rst.err", 32'(err_count), 32'd0);
      check("rst.first", 32'(first_fail_idx), 32'd0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle.hold", 32'({busy, done, dut_a, dut_b}), 32'd0);

      foreach (tbl[t]) begin
         fill_resp(tbl[t].fill, 0);
         run(tbl[t].name, tbl[t].n, tbl[t].gm, tbl[t].poke,
             tbl[t].e_err, tbl[t].e_first, tbl[t].e_pass);
      end

      // Abort a stuck-at-0 run on its fifth cycle, then restart cleanly.
      fill_resp(0, 0);
      gold_mode = 1'b0;
      drv = 1'b0;
      @(negedge clk);
      num_vectors = 8'd8;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort.outputs", 32'({dut_a, dut_b, busy, done, pass}), 32'd0);
      check("abort.err", 32'(err_count), 32'd0);
      check("abort.first", 32'(first_fail_idx), 32'd0);
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort.no_stale", 32'({err_count, busy, done}), 32'd0);
      run("abort.restart", 4, 1'b1, 1'b0, 0, 0, 1);

      // Random responses scored by the reference model
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 40);
         junk_kind = 2;
         for (int i = 0; i < 256; i++)
            resp[i] = and_of(i) ^ ($urandom_range(0, 3) == 0);
         ref_model(n, e, f, p);
         run($sformatf("rand%0d", r), n, 1'b0, 1'b0, e, f, p);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/and_pipe_checker.md
AND_PIPE_CHECKER -- requirements
Module: and_pipe_checker

Interface
REQ-001 The module SHALL have parameter LATENCY, default 2: cycles from a registered dut_a/dut_b change to the matching dut_out value.
REQ-002 The module SHALL have parameter CNT_W, default 8: width of the vector count, the error count and the index outputs.
REQ-003 The module SHALL have a single clock domain, and reset SHALL be synchronous and active-low.
REQ-004 Port: clock  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  synchronous, active-low reset.
REQ-006 Port: start  input  1  launches a test run; sampled only in IDLE or DONE.
REQ-007 Port: num_vectors  input  CNT_W  number of vectors to issue; sampled with start.
REQ-008 Port: dut_a, dut_b  output  1 each  registered stimulus driven to the DUT inputs.
REQ-009 Port: dut_out  input  1  DUT result.
REQ-010 Port: busy  output  1  high in RUN and DRAIN.
REQ-011 Port: done  output  1  high while in DONE.
REQ-012 Port: pass  output  1  valid when done; high when err_count==0.
REQ-013 Port: err_count  output  CNT_W  saturating mismatch count.
REQ-014 Port: first_fail_idx  output  CNT_W  index of the first mismatching vector; 0 if there is none.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE: start=1 with num_vectors>0 SHALL go to RUN; start=1 with num_vectors=0 SHALL go to DONE with pass=1; any other input SHALL stay in IDLE.
REQ-017 In RUN, each cycle SHALL issue vector idx (0..num_vectors-1): dut_a<=idx[0], dut_b<=idx[1], registered; idx SHALL increment by 1 per cycle.
REQ-018 After the cycle that issues vector num_vectors-1, the FSM SHALL enter DRAIN for exactly LATENCY cycles, then DONE.
REQ-019 In IDLE, DRAIN and DONE, dut_a and dut_b SHALL be 0.
REQ-020 An expected-value pipeline of LATENCY stages SHALL carry {valid, a&b, idx}; a stage SHALL be loaded with valid=1 only for issued vectors.
REQ-021 Vector i, visible on dut_a/dut_b in cycle c0+i, SHALL be compared against dut_out sampled in cycle c0+i+LATENCY.
REQ-022 On a mismatch at a valid stage, err_count SHALL increment and saturate at 2^CNT_W-1 with no wrap.
REQ-023 On the first mismatch of a run, first_fail_idx SHALL capture that idx; later mismatches SHALL NOT overwrite it.
REQ-024 busy SHALL be high for exactly num_vectors+LATENCY cycles per run.
REQ-025 DONE SHALL hold done=1 and pass=(err_count==0) until start=1, which SHALL clear err_count and first_fail_idx and behave as in IDLE per REQ-016.
REQ-026 start SHALL be ignored in RUN and DRAIN, and num_vectors SHALL be latched on the start cycle only.
REQ-027 Compares SHALL occur only for valid pipeline stages; dut_out SHALL be ignored otherwise, including the first LATENCY cycles of RUN.

Reset
REQ-028 When reset=0 at a rising edge, the module SHALL enter IDLE and clear the pipeline valid bits, idx, err_count, first_fail_idx, dut_a, dut_b, busy, done and pass to 0.
REQ-029 Reset asserted mid-RUN or mid-DRAIN SHALL abort the run; no stale compare SHALL occur after reset is released.

Verification
REQ-030 Golden 2-cycle registered AND DUT, num_vectors=8, start pulse -> busy for 10 cycles, then done=1, pass=1, err_count=0, first_fail_idx=0.
REQ-031 dut_out stuck at 0, num_vectors=8 -> mismatches at idx 3 and 7; err_count=2, first_fail_idx=3, pass=0.
REQ-032 dut_out stuck at 1, num_vectors=8 -> err_count=6, first_fail_idx=0, pass=0.
REQ-033 num_vectors=0 with start -> done=1 on the next cycle, pass=1, busy never high, dut_a=dut_b=0 throughout.
REQ-034 reset=0 for one cycle at the 5th RUN cycle of a stuck-at-0 run -> state IDLE and all outputs 0; a restart with a golden DUT and num_vectors=4 -> pass=1, err_count=0.
REQ-035 dut_out = ~expected, CNT_W=8, num_vectors=255 -> err_count=255 with no wrap, first_fail_idx=0; start pressed during RUN has no effect.
